// File: rtl/genius_pkg.sv
// Shared types, constants and helpers for the Genius game datapath
// (round counter, sequence player, input checker).
package genius_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_ON   = 3'd2,
        ST_OFF  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    typedef logic [1:0] color_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Feedback taps l[7]^l[5]^l[4]^l[3]
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic lfsr_feedback(input logic [7:0] state);
        return ^(state & LFSR_TAPS);
    endfunction

    function automatic logic [3:0] onehot_color(input color_t color);
        logic [3:0] led;
        case (color)
            2'd0:    led = 4'b0001;
            2'd1:    led = 4'b0010;
            2'd2:    led = 4'b0100;
            2'd3:    led = 4'b1000;
            default: led = 4'b0000;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; the nonzero seed keeps it off the
// all-zero lockup state.
module lfsr8
    import genius_pkg::*;
(
    input  logic       clk_i,
    input  logic       r_i,
    output logic [7:0] state_o
);

    logic [7:0] state_r;

    // Shift register advancing every cycle out of reset
    always_ff @(posedge clk_i) begin
        if (!r_i) begin
            state_r <= LFSR_SEED;
        end else begin
            state_r <= {state_r[6:0], lfsr_feedback(state_r)};
        end
    end

    assign state_o = state_r;

endmodule

// File: rtl/sequence_player.sv
// Genius playback stage: fills a random colour sequence and flashes its
// prefix 0..round on one-hot LEDs with a tick-driven on/off cadence.
module sequence_player
    import genius_pkg::*;
#(
    parameter int N     = 4,
    parameter int T_ON  = 4,
    parameter int T_OFF = 2
) (
    input  logic         clk_i,
    input  logic         r_i,
    input  logic         tick_i,
    input  logic         new_i,
    input  logic         start_i,
    input  logic [N-1:0] round_i,
    input  logic [N-1:0] addr_i,
    output logic [1:0]   color_o,
    output logic [3:0]   led_o,
    output logic [N-1:0] idx_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam int DEPTH   = 2 ** N;
    localparam int CNT_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(T_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(T_OFF - 1);
    localparam logic [N-1:0]     IDX_LAST = {N{1'b1}};

    state_t         state_r, state_s;
    logic [N-1:0]   idx_r, idx_s;
    logic [N-1:0]   round_r, round_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic           fill_we_s;
    color_t         seq_r [DEPTH];
    logic [3:0]     led_r, led_s;
    logic           busy_r, busy_s;
    logic           done_r, done_s;
    logic [7:0]     lfsr_s;
    logic           lfsr_unused_s;

    lfsr8 u_lfsr (
        .clk_i   (clk_i),
        .r_i     (r_i),
        .state_o (lfsr_s)
    );

    // Only the low two bits seed a colour
    assign lfsr_unused_s = ^lfsr_s[7:2];

    // Next-state, index, phase counter and fill write enable
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        cnt_s     = cnt_r;
        round_s   = round_r;
        fill_we_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (new_i) begin
                    state_s = ST_FILL;
                    idx_s   = {N{1'b0}};
                end else if (start_i) begin
                    state_s = ST_ON;
                    idx_s   = {N{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                    round_s = round_i;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                fill_we_s = 1'b1;
                if (idx_r == IDX_LAST) begin
                    state_s = ST_IDLE;
                    idx_s   = {N{1'b0}};
                end else begin
                    idx_s = idx_r + N'(1);
                end
            end
            ST_ON: begin
                if (tick_i && (cnt_r == ON_LAST)) begin
                    state_s = ST_OFF;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (tick_i) begin
                    cnt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_OFF: begin
                if (tick_i && (cnt_r == OFF_LAST)) begin
                    cnt_s = {CNT_W{1'b0}};
                    if (idx_r == round_r) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_ON;
                        idx_s   = idx_r + N'(1);
                    end
                end else if (tick_i) begin
                    cnt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from the next state so they register in step with it
    always_comb begin
        led_s  = 4'b0000;
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_s)
            ST_FILL: busy_s = 1'b1;
            ST_ON: begin
                busy_s = 1'b1;
                led_s  = onehot_color(seq_r[idx_s]);
            end
            ST_OFF:  busy_s = 1'b1;
            ST_DONE: done_s = 1'b1;
            default: busy_s = 1'b0;
        endcase
    end

    // State, counters, sequence storage and registered outputs
    always_ff @(posedge clk_i) begin
        if (!r_i) begin
            state_r <= ST_IDLE;
            idx_r   <= {N{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            round_r <= {N{1'b0}};
            led_r   <= 4'b0000;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                seq_r[i] <= 2'd0;
            end
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            round_r <= round_s;
            led_r   <= led_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            if (fill_we_s) begin
                seq_r[idx_r] <= lfsr_s[1:0];
            end
        end
    end

    assign color_o = seq_r[addr_i];
    assign led_o   = led_r;
    assign idx_o   = idx_r;
    assign busy_o  = busy_r;
    assign done_o  = done_r;

endmodule
